// File: rtl/eth_mac_filter_multi.sv
// Receive-path destination MAC filter: programmable unicast slots plus broadcast,
// multicast and promiscuous modes, with early rejection and saturating frame counters.
module eth_mac_filter_multi #(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 n_ss,
  input  logic                 byte_we,
  input  logic [7:0]           byte_d,
  input  logic                 cfg_we,
  input  logic [SLOT_W-1:0]    cfg_slot,
  input  logic [2:0]           cfg_idx,
  input  logic [7:0]           cfg_d,
  input  logic [NUM_SLOTS-1:0] slot_en,
  input  logic                 accept_bcast,
  input  logic                 accept_mcast,
  input  logic                 promisc,
  output logic                 n_inhibit,
  output logic                 verdict_vld,
  output logic                 accepted,
  output logic [SLOT_W-1:0]    match_slot,
  output logic [CNT_W-1:0]     cnt_accept,
  output logic [CNT_W-1:0]     cnt_drop
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_PASS = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  logic [7:0]           r_tbl [NUM_SLOTS][6];
  logic [1:0]           r_state;
  logic [2:0]           r_cnt;
  logic [NUM_SLOTS-1:0] r_cand_slot;
  logic                 r_cand_bcast;
  logic                 r_cand_mcast;
  logic                 r_armed;
  logic                 r_n_inhibit;
  logic                 r_verdict_vld;
  logic                 r_accepted;
  logic [SLOT_W-1:0]    r_match_slot;
  logic [CNT_W-1:0]     r_cnt_accept;
  logic [CNT_W-1:0]     r_cnt_drop;

  logic [NUM_SLOTS-1:0] w_slot_hit;
  logic                 w_bcast_hit;
  logic                 w_mcast_hit;
  logic                 w_any;
  logic                 w_last;
  logic [SLOT_W-1:0]    w_lowest;

  // Slot table and per-slot comparators; a write in the compare cycle lands after the compare.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          for (int b = 0; b < 6; b++) r_tbl[gi][b] <= '0;
        end else if (cfg_we && (cfg_slot == SLOT_W'(gi)) && (cfg_idx < 3'd6)) begin
          r_tbl[gi][cfg_idx] <= cfg_d;
        end
      end

      assign w_slot_hit[gi] = r_cand_slot[gi] & slot_en[gi] & (byte_d == r_tbl[gi][r_cnt]);
    end
  endgenerate

  assign w_bcast_hit = r_cand_bcast & accept_bcast & (byte_d == 8'hff);
  // Multicast is decided by the group bit of byte 0 and simply held afterwards.
  assign w_mcast_hit = (r_cnt == 3'd0) ? (accept_mcast & byte_d[0]) : r_cand_mcast;
  assign w_any       = (|w_slot_hit) | w_bcast_hit | w_mcast_hit;
  assign w_last      = (r_cnt == 3'd5);

  always_comb begin
    w_lowest = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (w_slot_hit[i]) w_lowest = SLOT_W'(i);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_cand_slot   <= '0;
      r_cand_bcast  <= 1'b0;
      r_cand_mcast  <= 1'b0;
      r_armed       <= 1'b0;
      r_n_inhibit   <= 1'b1;
      r_verdict_vld <= 1'b0;
      r_accepted    <= 1'b0;
      r_match_slot  <= '0;
      r_cnt_accept  <= '0;
      r_cnt_drop    <= '0;
    end else if (n_ss) begin
      r_state       <= ST_IDLE;
      r_armed       <= 1'b1;
      r_n_inhibit   <= 1'b1;
      r_verdict_vld <= 1'b0;
      r_accepted    <= 1'b0;
      r_match_slot  <= '0;
      // Runts that end inside the address count as drops.
      if (r_state == ST_PASS) begin
        if (r_cnt_accept != {CNT_W{1'b1}}) r_cnt_accept <= r_cnt_accept + CNT_W'(1);
      end else if ((r_state == ST_ADDR) || (r_state == ST_DROP)) begin
        if (r_cnt_drop != {CNT_W{1'b1}}) r_cnt_drop <= r_cnt_drop + CNT_W'(1);
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A frame only starts after n_ss has been seen high since reset.
          if (r_armed) begin
            r_state      <= ST_ADDR;
            r_armed      <= 1'b0;
            r_cnt        <= '0;
            r_cand_slot  <= '1;
            r_cand_bcast <= 1'b1;
            r_cand_mcast <= 1'b1;
          end
        end
        ST_ADDR: begin
          if (byte_we) begin
            r_cnt        <= r_cnt + 3'd1;
            r_cand_slot  <= w_slot_hit;
            r_cand_bcast <= w_bcast_hit;
            r_cand_mcast <= w_mcast_hit;
            if (!w_any && !promisc) begin
              r_state       <= ST_DROP;
              r_n_inhibit   <= 1'b0;
              r_verdict_vld <= 1'b1;
              r_accepted    <= 1'b0;
              r_match_slot  <= '0;
            end else if (w_last) begin
              r_state       <= ST_PASS;
              r_verdict_vld <= 1'b1;
              r_accepted    <= 1'b1;
              r_match_slot  <= w_lowest;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign n_inhibit   = r_n_inhibit;
  assign verdict_vld = r_verdict_vld;
  assign accepted    = r_accepted;
  assign match_slot  = r_match_slot;
  assign cnt_accept  = r_cnt_accept;
  assign cnt_drop    = r_cnt_drop;

endmodule

// File: tb/tb_eth_mac_filter_multi.sv
// Randomized scoreboard bench for eth_mac_filter_multi against a prefix-match reference model.
module tb_eth_mac_filter_multi;

  localparam int NS    = 4;
  localparam int SW    = 2;
  localparam int CW    = 2;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          n_ss = 1'b1;
  logic          byte_we = 1'b0;
  logic [7:0]    byte_d = '0;
  logic          cfg_we = 1'b0;
  logic [SW-1:0] cfg_slot = '0;
  logic [2:0]    cfg_idx = '0;
  logic [7:0]    cfg_d = '0;
  logic [NS-1:0] slot_en = '0;
  logic          accept_bcast = 1'b0;
  logic          accept_mcast = 1'b0;
  logic          promisc = 1'b0;
  logic          n_inhibit;
  logic          verdict_vld;
  logic          accepted;
  logic [SW-1:0] match_slot;
  logic [CW-1:0] cnt_accept;
  logic [CW-1:0] cnt_drop;

  eth_mac_filter_multi #(.NUM_SLOTS(NS), .SLOT_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .n_rst(n_rst), .n_ss(n_ss), .byte_we(byte_we), .byte_d(byte_d),
    .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_idx(cfg_idx), .cfg_d(cfg_d),
    .slot_en(slot_en), .accept_bcast(accept_bcast), .accept_mcast(accept_mcast),
    .promisc(promisc), .n_inhibit(n_inhibit), .verdict_vld(verdict_vld),
    .accepted(accepted), .match_slot(match_slot), .cnt_accept(cnt_accept),
    .cnt_drop(cnt_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         acc;
    logic [1:0] slot;
    int         nb;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         failures = 0;
  int         mon_seen = 0;
  bit         mon_prev = 1'b0;
  logic [7:0] m_tbl [NS][6];
  int         exp_acc = 0;
  int         exp_drop = 0;
  int         frame_no = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s frame=%0d actual=%0d required=%0d", name, frame_no, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] dbyte(input logic [47:0] dest, input int k);
    return dest[47 - 8*k -: 8];
  endfunction

  function automatic bit pfx_eq(input int i, input logic [47:0] dest, input int k);
    for (int j = 0; j <= k; j++) if (m_tbl[i][j] != dbyte(dest, j)) return 1'b0;
    return 1'b1;
  endfunction

  // Reference: a candidate survives byte k iff its rule holds for the whole prefix 0..k.
  function automatic void model_decide(input logic [47:0] dest, output int dk,
                                       output bit acc, output logic [1:0] sl);
    bit any;
    bit all_ff;
    dk = 5; acc = 1'b1; sl = 2'd0;
    for (int k = 0; k < 6; k++) begin
      any = 1'b0;
      for (int i = 0; i < NS; i++) if (slot_en[i] && pfx_eq(i, dest, k)) any = 1'b1;
      all_ff = 1'b1;
      for (int j = 0; j <= k; j++) if (dbyte(dest, j) != 8'hff) all_ff = 1'b0;
      if (accept_bcast && all_ff) any = 1'b1;
      if (accept_mcast && dest[40]) any = 1'b1;
      if (!any && !promisc) begin
        dk = k; acc = 1'b0;
        return;
      end
    end
    for (int i = NS - 1; i >= 0; i--) if (slot_en[i] && pfx_eq(i, dest, 5)) sl = 2'(i);
  endfunction

  task automatic cfg_write(input int slot, input int idx, input logic [7:0] d);
    cfg_we = 1'b1; cfg_slot = SW'(slot); cfg_idx = 3'(idx); cfg_d = d;
    tick();
    cfg_we = 1'b0;
    if (idx < 6) m_tbl[slot][idx] = d;
  endtask

  task automatic cfg_addr(input int slot, input logic [47:0] a);
    for (int k = 0; k < 6; k++) cfg_write(slot, k, dbyte(a, k));
  endtask

  // One frame: nbytes strobed bytes; end_we strobes one more byte in the n_ss-high cycle;
  // cfg_at >= 0 rewrites slot 0 byte cfg_at in the same cycle that byte is compared.
  task automatic send_frame(input logic [47:0] dest, input int nbytes, input bit end_we,
                            input int cfg_at);
    int         dk;
    bit         acc;
    logic [1:0] sl;
    bit         vd;
    logic [7:0] nb_val;
    frame_no++;
    model_decide(dest, dk, acc, sl);
    vd = (dk < nbytes);
    if (vd) sb_q.push_back('{acc: acc, slot: sl, nb: dk + 1});
    n_ss = 1'b0;
    tick();
    for (int b = 0; b < nbytes; b++) begin
      byte_we = 1'b1;
      byte_d  = (b < 6) ? dbyte(dest, b) : 8'($urandom);
      if (b == cfg_at) begin
        cfg_we = 1'b1; cfg_slot = '0; cfg_idx = 3'(b); cfg_d = ~dbyte(dest, b);
      end
      tick();
      byte_we = 1'b0;
      cfg_we  = 1'b0;
      if (b == cfg_at) m_tbl[0][b] = ~dbyte(dest, b);
      if ($urandom_range(99) < 25) tick();
    end
    if (end_we) begin
      byte_we = 1'b1;
      byte_d  = (nbytes < 6) ? dbyte(dest, nbytes) : 8'($urandom);
    end
    nb_val = byte_d;
    n_ss = 1'b1;
    tick();
    byte_we = 1'b0;
    if (vd && acc) begin
      if (exp_acc < CMAX) exp_acc++;
    end else begin
      if (exp_drop < CMAX) exp_drop++;
    end
    chk("end_vld", verdict_vld, 0);
    chk("end_inhibit", n_inhibit, 1);
    chk("cnt_accept", cnt_accept, exp_acc);
    chk("cnt_drop", cnt_drop, exp_drop);
    if (nb_val == 8'h00) tick();
    tick();
  endtask

  // Monitor: pops the scoreboard on each new verdict and checks the inhibit invariant every cycle.
  always @(negedge clk) begin
    if (!n_rst) begin
      mon_prev = 1'b0;
      mon_seen = 0;
    end else begin
      if (verdict_vld && !mon_prev) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_verdict", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("accepted", accepted, mon_e.acc);
          if (mon_e.acc) chk("match_slot", match_slot, mon_e.slot);
          chk("decide_byte", mon_seen, mon_e.nb);
        end
      end
      chk("inhibit_vs_verdict", n_inhibit, !(verdict_vld && !accepted));
      mon_prev = verdict_vld;
      if (n_ss) mon_seen = 0;
      else if (byte_we) mon_seen++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog frame=%0d actual=timeout required=finish", frame_no);
    $fatal(1, "watchdog");
  end

  localparam logic [47:0] ADDR_A = 48'h02_11_22_33_44_55;
  localparam logic [47:0] ADDR_B = 48'h0a_bb_cc_dd_ee_01;

  initial begin
    logic [47:0] d;
    int          r;
    int          s;
    for (int i = 0; i < NS; i++) for (int k = 0; k < 6; k++) m_tbl[i][k] = '0;
    tick(); tick();
    chk("rst_inhibit", n_inhibit, 1);
    chk("rst_vld", verdict_vld, 0);
    chk("rst_accepted", accepted, 0);
    chk("rst_match", match_slot, 0);
    chk("rst_cnt_acc", cnt_accept, 0);
    chk("rst_cnt_drop", cnt_drop, 0);
    n_rst = 1'b1;
    tick(); tick();

    cfg_addr(0, ADDR_A);
    slot_en = 4'b0001;
    send_frame(ADDR_A, 20, 1'b0, -1);
    send_frame(48'h02_12_22_33_44_55, 20, 1'b0, -1);
    accept_bcast = 1'b1;
    send_frame(48'hff_ff_ff_ff_ff_ff, 10, 1'b0, -1);
    accept_bcast = 1'b0;
    send_frame(48'hff_ff_ff_ff_ff_ff, 10, 1'b0, -1);
    cfg_addr(1, ADDR_B);
    cfg_addr(3, ADDR_B);
    slot_en = 4'b1010;
    send_frame(ADDR_B, 8, 1'b0, -1);
    slot_en = 4'b0001;
    accept_mcast = 1'b1;
    send_frame(48'h01_00_5e_00_00_01, 8, 1'b0, -1);
    accept_mcast = 1'b0;
    promisc = 1'b1;
    send_frame(48'h9c_37_5a_e1_00_42, 8, 1'b0, -1);
    promisc = 1'b0;
    send_frame(ADDR_A, 3, 1'b0, -1);
    send_frame(ADDR_A, 5, 1'b1, -1);
    send_frame(ADDR_A, 8, 1'b0, 3);
    send_frame(ADDR_A, 8, 1'b0, -1);
    cfg_write(0, 3, dbyte(ADDR_A, 3));
    cfg_write(0, 6, 8'h00);
    send_frame(ADDR_A, 8, 1'b0, -1);

    // Asynchronous reset while a rejected frame is in progress.
    frame_no++;
    n_ss = 1'b0;
    tick();
    sb_q.push_back('{acc: 1'b0, slot: 2'd0, nb: 1});
    byte_we = 1'b1; byte_d = 8'h77;
    tick();
    byte_we = 1'b0;
    tick();
    chk("pre_rst_inhibit", n_inhibit, 0);
    #2 n_rst = 1'b0;
    #1;
    chk("midrst_inhibit", n_inhibit, 1);
    chk("midrst_vld", verdict_vld, 0);
    chk("midrst_accepted", accepted, 0);
    chk("midrst_match", match_slot, 0);
    chk("midrst_cnt_acc", cnt_accept, 0);
    chk("midrst_cnt_drop", cnt_drop, 0);
    n_ss = 1'b1;
    tick(); tick();
    n_rst = 1'b1;
    for (int i = 0; i < NS; i++) for (int k = 0; k < 6; k++) m_tbl[i][k] = '0;
    exp_acc = 0; exp_drop = 0;
    tick();

    cfg_addr(0, ADDR_A);
    slot_en = 4'b0001;
    for (int n = 0; n < 5; n++) send_frame(ADDR_A, 7, 1'b0, -1);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(4) == 0) begin
        s = $urandom_range(NS - 1);
        if ($urandom_range(1) == 0) d = {$urandom, 16'($urandom)};
        else begin
          r = $urandom_range(NS - 1);
          for (int k = 0; k < 6; k++) d[47 - 8*k -: 8] = m_tbl[r][k];
        end
        cfg_addr(s, d);
      end
      slot_en      = NS'($urandom);
      accept_bcast = 1'($urandom);
      accept_mcast = 1'($urandom);
      promisc      = ($urandom_range(9) == 0);
      r = $urandom_range(9);
      if (r <= 3) begin
        s = $urandom_range(NS - 1);
        for (int k = 0; k < 6; k++) d[47 - 8*k -: 8] = m_tbl[s][k];
        if (r == 3) d[47 - 8*$urandom_range(5) -: 8] ^= 8'(1 + $urandom_range(254));
      end else if (r <= 5) begin
        d = 48'hff_ff_ff_ff_ff_ff;
        if (r == 5) d[47 - 8*$urandom_range(5) -: 8] = 8'h7e;
      end else begin
        d = {$urandom, 16'($urandom)};
        if (r <= 7) d[40] = 1'b1;
      end
      send_frame(d, ($urandom_range(7) == 0) ? $urandom_range(1, 5) : 6 + $urandom_range(6),
                 ($urandom_range(3) == 0), -1);
    end

    tick(); tick();
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
